// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_pkg
// Description : Shared frame sizing, counter widths and FSM state encoding
//               for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_master_pkg;

  // Bytes per transaction: instruction, address MSB, address LSB, data
  localparam int unsigned FRAME_BYTES = 4;
  localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;

  localparam int unsigned HALF_CNT_W  = 8;
  localparam int unsigned BIT_CNT_W   = 6;

  // Index of the final bit of a frame in the bit counter's width
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_if
// Description : Host handshake plus SPI pin bundle. The "master" modport is
//               the view of the spi_master block itself; the "slave" modport
//               is the view of its environment (host and SPI slave device).
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if;
  logic       start;
  logic [7:0] instr;
  logic [7:0] addr_msb;
  logic [7:0] addr_lsb;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       SCLK;
  logic       MOSI;
  logic       SS;
  logic       MISO;

  modport master (
    input  start, instr, addr_msb, addr_lsb, wdata, MISO,
    output busy, done, rdata, SCLK, MOSI, SS
  );

  modport slave (
    output start, instr, addr_msb, addr_lsb, wdata, MISO,
    input  busy, done, rdata, SCLK, MOSI, SS
  );
endinterface
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : Half-period tick generator and SCLK level register. The tick
//               fires on the last clk cycle of each CLK_DIV-long half period;
//               SCLK toggles on a tick only while sclk_en_i is high.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic sclk_en_i,
  output logic tick_o,
  output logic sclk_o
);

  localparam logic [HALF_CNT_W-1:0] TERM = HALF_CNT_W'(CLK_DIV - 1);

  logic [HALF_CNT_W-1:0] cnt_q;
  logic                  sclk_q;

  assign tick_o = en_i && !clr_i && (cnt_q == TERM);
  assign sclk_o = sclk_q;

  // Half-period counter and SCLK level; clear restarts a fresh low phase
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (en_i) begin
      if (cnt_q == TERM) begin
        cnt_q <= '0;
        if (sclk_en_i) begin
          sclk_q <= ~sclk_q;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Mode-0 SPI master sending a fixed 4-byte frame (instruction,
//               address MSB, address LSB, data) MSB first and capturing the
//               MISO byte seen during the data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  spi_master_if.master bus
);

  state_e                 state_q;
  logic [FRAME_BITS-1:0]  tx_q;
  logic [7:0]             rx_q;      // only the last byte received is kept
  logic [BIT_CNT_W-1:0]   bit_q;
  logic                   ss_q;
  logic                   busy_q;
  logic                   done_q;
  logic [7:0]             rdata_q;

  logic                   w_tick;
  logic                   w_sclk;
  logic                   w_accept;
  logic                   w_gen_en;
  logic                   w_sclk_en;

  assign w_accept  = (state_q == ST_IDLE) && bus.start;
  assign w_gen_en  = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD);
  assign w_sclk_en = (state_q == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (w_gen_en),
    .clr_i     (w_accept),
    .sclk_en_i (w_sclk_en),
    .tick_o    (w_tick),
    .sclk_o    (w_sclk)
  );

  // MOSI is the shift-register MSB; it is zero outside a frame because the
  // frame is shifted fully out before SS returns high.
  assign bus.MOSI  = tx_q[FRAME_BITS-1];
  assign bus.SCLK  = w_sclk;
  assign bus.SS    = ss_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

  // Transaction sequencer: SETUP, 32 bit periods, HOLD, then a done pulse
  // that is registered one cycle after the DONE state is entered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ss_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.start) begin
            tx_q    <= {bus.instr, bus.addr_msb, bus.addr_lsb, bus.wdata};
            rx_q    <= '0;
            bit_q   <= '0;
            ss_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!w_sclk) begin
              // SCLK is about to rise: capture the slave's bit
              rx_q <= {rx_q[6:0], bus.MISO};
            end else begin
              // SCLK is about to fall: present the next bit
              tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
              if (bit_q == LAST_BIT) begin
                state_q <= ST_HOLD;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            ss_q    <= 1'b1;
            busy_q  <= 1'b0;
            rdata_q <= rx_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
